wb_port_arbiter: RTL and testbench

//  Arbitrates the single register-file write port between the ALU pipe and the load unit.

---
 rtl/wb_pkg.sv | 18 +
 rtl/wb_port_arbiter_if.sv | 36 +++
 rtl/wb_ldq.sv | 61 ++++++
 rtl/wb_port_arbiter.sv | 99 +++++++++
 tb/tb_wb_port_arbiter.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared types and default widths for the writeback port arbiter.
// Consumers pick up the write-request record and source tag from here.
package wb_pkg;

    localparam int DEFAULT_XLEN    = 64;
    localparam int DEFAULT_REGBITS = 5;

    typedef struct packed {
        logic [DEFAULT_REGBITS-1:0] rd;
        logic [DEFAULT_XLEN-1:0]    data;
    } wb_req_t;

    typedef enum logic {
        WB_ALU = 1'b0,
        WB_LD  = 1'b1
    } wb_src_e;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Producer handshakes, registered regfile write port and queue occupancy.
// "master" is the producer/regfile side, "slave" is the arbiter.
interface wb_port_arbiter_if
    import wb_pkg::*;
#(
    parameter int XLEN    = DEFAULT_XLEN,
    parameter int REGBITS = DEFAULT_REGBITS,
    parameter int CNT_W   = 2
);
    logic               alu_valid;
    logic               alu_ready;
    logic [REGBITS-1:0] alu_rd;
    logic [XLEN-1:0]    alu_data;

    logic               ld_valid;
    logic               ld_ready;
    logic [REGBITS-1:0] ld_rd;
    logic [XLEN-1:0]    ld_data;

    logic               wr_en;
    logic [REGBITS-1:0] wr_addr;
    logic [XLEN-1:0]    wr_data;
    logic               wr_src;
    logic [CNT_W-1:0]   ldq_count;

    modport master (
        output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
        input  alu_ready, ld_ready, wr_en, wr_addr, wr_data, wr_src, ldq_count
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
        output alu_ready, ld_ready, wr_en, wr_addr, wr_data, wr_src, ldq_count
    );

endinterface

// File: rtl/wb_ldq.sv
// Small synchronous FIFO holding returned loads until they win the write port.
// Push is ignored when full and pop when empty; push and pop may share a cycle.
module wb_ldq
    import wb_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type req_t = wb_req_t
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  req_t                       push_data,
    input  logic                       pop,
    output req_t                       head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    req_t             mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];
    assign count   = count_q;

    // NOTE: storage is deliberately not reset; count_q alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single regfile write port between the ALU pipe and queued loads,
// with an ALU-streak limit so waiting loads cannot starve.
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int XLEN           = DEFAULT_XLEN,
    parameter int REGBITS        = DEFAULT_REGBITS,
    parameter int LDQ_DEPTH      = 2,
    parameter int MAX_ALU_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    wb_port_arbiter_if.slave  bus
);
    localparam int STK_W = $clog2(MAX_ALU_STREAK + 1);

    typedef struct packed {
        logic [REGBITS-1:0] rd;
        logic [XLEN-1:0]    data;
    } req_t;

    req_t               push_req;
    req_t               head;
    logic               full;
    logic               empty;
    logic               pend;
    logic               push;
    logic               grant_ld;
    logic               grant_alu;
    logic [STK_W-1:0]   streak;

    logic               wr_en_q;
    logic [REGBITS-1:0] wr_addr_q;
    logic [XLEN-1:0]    wr_data_q;
    wb_src_e            wr_src_q;

    assign push_req = '{rd: bus.ld_rd, data: bus.ld_data};
    assign pend     = !empty;

    // A waiting load wins when the ALU is idle, the queue is full, or the ALU has used its streak.
    assign grant_ld  = !rst && pend &&
                       (!bus.alu_valid || full || streak == STK_W'(MAX_ALU_STREAK));
    assign grant_alu = !rst && bus.alu_valid && !grant_ld;

    assign bus.alu_ready = !rst && !grant_ld;
    assign bus.ld_ready  = !rst && !full;
    assign push          = bus.ld_valid && bus.ld_ready;

    wb_ldq #(
        .DEPTH (LDQ_DEPTH),
        .req_t (req_t)
    ) u_ldq (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_req),
        .pop       (grant_ld),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (bus.ldq_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            streak    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_src_q  <= WB_ALU;
        end else begin
            if (grant_ld || !pend) begin
                streak <= '0;
            end else if (grant_alu && streak != STK_W'(MAX_ALU_STREAK)) begin
                streak <= streak + 1'b1;
            end

            // x0 writes still complete the handshake but never strobe the regfile.
            wr_en_q <= 1'b0;
            if (grant_ld) begin
                wr_en_q   <= (head.rd != '0);
                wr_addr_q <= head.rd;
                wr_data_q <= head.data;
                wr_src_q  <= WB_LD;
            end else if (grant_alu) begin
                wr_en_q   <= (bus.alu_rd != '0);
                wr_addr_q <= bus.alu_rd;
                wr_data_q <= bus.alu_data;
                wr_src_q  <= WB_ALU;
            end
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign bus.wr_src  = wr_src_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: queue-based reference model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_wb_port_arbiter;
    import wb_pkg::*;

    localparam int XLEN    = 64;
    localparam int REGBITS = 5;
    localparam int DEPTH   = 2;
    localparam int MAXS    = 4;
    localparam int CNT_W   = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    wb_port_arbiter_if #(.XLEN(XLEN), .REGBITS(REGBITS), .CNT_W(CNT_W)) bus ();

    wb_port_arbiter #(
        .XLEN(XLEN), .REGBITS(REGBITS), .LDQ_DEPTH(DEPTH), .MAX_ALU_STREAK(MAXS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO of waiting loads and a count of ALU wins while a load waits.
    wb_req_t          q[$];
    int               m_streak = 0;
    bit               model_ok = 0;
    bit               exp_en, exp_src, exp_src_chk, exp_zero;
    logic [REGBITS-1:0] exp_addr;
    logic [XLEN-1:0]  exp_data;

    always @(negedge clk) begin
        int      cnt;
        bit      pend, full, gl, ga, exp_ar, exp_lr;
        wb_req_t item;

        if (model_ok) begin
            check("m_wr_en", bus.wr_en, exp_en);
            if (exp_en) begin
                check("m_wr_addr", bus.wr_addr, exp_addr);
                check("m_wr_data", bus.wr_data, exp_data);
            end
            if (exp_src_chk) check("m_wr_src", bus.wr_src, exp_src);
            if (exp_zero) begin
                check("m_rst_addr", bus.wr_addr, 0);
                check("m_rst_data", bus.wr_data, 0);
                check("m_rst_src",  bus.wr_src,  0);
            end
        end

        cnt  = q.size();
        pend = cnt > 0;
        full = cnt == DEPTH;
        if (rst) begin
            gl = 0; exp_ar = 0; exp_lr = 0;
        end else begin
            gl = pend && (!bus.alu_valid || full || m_streak == MAXS);
            exp_ar = !gl;
            exp_lr = !full;
        end
        if (model_ok || rst) begin
            check("m_alu_ready", bus.alu_ready, exp_ar);
            check("m_ld_ready",  bus.ld_ready,  exp_lr);
        end
        if (model_ok) check("m_ldq_count", bus.ldq_count, cnt);

        if (rst) begin
            q.delete();
            m_streak = 0;
            exp_en = 0; exp_zero = 1; exp_src_chk = 0;
            model_ok = 1;
        end else begin
            ga = bus.alu_valid && !gl;
            exp_zero = 0;
            exp_en = 0;
            exp_src_chk = gl || ga;
            if (gl) begin
                item = q.pop_front();
                exp_en = item.rd != 0; exp_addr = item.rd; exp_data = item.data; exp_src = 1;
            end else if (ga) begin
                exp_en = bus.alu_rd != 0; exp_addr = bus.alu_rd; exp_data = bus.alu_data; exp_src = 0;
            end
            if (bus.ld_valid && exp_lr) q.push_back(wb_req_t'{rd: bus.ld_rd, data: bus.ld_data});
            if (gl || !pend) m_streak = 0;
            else if (ga && m_streak < MAXS) m_streak++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic drive_alu(input bit v, input int rd, input logic [63:0] d);
        bus.alu_valid = v; bus.alu_rd = REGBITS'(rd); bus.alu_data = d;
    endtask

    task automatic drive_ld(input bit v, input int rd, input logic [63:0] d);
        bus.ld_valid = v; bus.ld_rd = REGBITS'(rd); bus.ld_data = d;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        int alu_wr;
        rst = 1'b1;
        drive_alu(0, 0, 0);
        drive_ld(0, 0, 0);
        step(); step();
        rst = 1'b0;
        mid();
        check("rst_wr_en", bus.wr_en, 0);
        check("rst_count", bus.ldq_count, 0);

        // ALU only
        step(); drive_alu(1, 3, 64'hA5);
        mid();  check("alu_ready", bus.alu_ready, 1);
        step(); drive_alu(0, 0, 0);
        mid();
        check("alu_wr_en",   bus.wr_en,   1);
        check("alu_wr_addr", bus.wr_addr, 3);
        check("alu_wr_data", bus.wr_data, 64'hA5);
        check("alu_wr_src",  bus.wr_src,  0);

        // Load only: count at N+1, write at N+2
        step(); drive_ld(1, 7, 64'h1234);
        mid();  check("ld_ready", bus.ld_ready, 1);
        step(); drive_ld(0, 0, 0);
        mid();
        check("ld_count1", bus.ldq_count, 1);
        check("ld_wr_en0", bus.wr_en, 0);
        step(); mid();
        check("ld_wr_en",   bus.wr_en,   1);
        check("ld_wr_addr", bus.wr_addr, 7);
        check("ld_wr_data", bus.wr_data, 64'h1234);
        check("ld_wr_src",  bus.wr_src,  1);
        check("ld_count0",  bus.ldq_count, 0);

        // Starvation limit: four ALU wins while the load waits, then the load
        step(); drive_alu(1, 1, 64'h11); drive_ld(1, 9, 64'h99);
        mid();
        alu_wr = 0;
        for (int c = 1; c <= 6; c++) begin
            step();
            if (c == 1) drive_ld(0, 0, 0);
            mid();
            if (c >= 2 && c <= 5 && bus.wr_en && bus.wr_src == 1'b0) alu_wr++;
            if (c == 5) check("starve_alu_ready", bus.alu_ready, 0);
            if (c == 6) begin
                check("starve_ld_src",  bus.wr_src,  1);
                check("starve_ld_addr", bus.wr_addr, 9);
                check("starve_ld_data", bus.wr_data, 64'h99);
            end
        end
        check("starve_alu_writes", alu_wr, 4);
        step(); drive_alu(0, 0, 0);

        // Full queue forces the load grant and blocks further loads for one cycle
        step(); drive_alu(1, 2, 64'h22); drive_ld(1, 4, 64'h44);
        step(); drive_ld(1, 5, 64'h55);
        step(); drive_ld(1, 6, 64'h66);
        mid();
        check("full_count",     bus.ldq_count, 2);
        check("full_ld_ready",  bus.ld_ready,  0);
        check("full_alu_ready", bus.alu_ready, 0);
        step(); mid();
        check("full_ld_ready_next", bus.ld_ready, 1);
        check("full_count_next",    bus.ldq_count, 1);
        step(); drive_alu(0, 0, 0); drive_ld(0, 0, 0);
        step(); step(); step();
        mid();
        check("drain_count", bus.ldq_count, 0);

        // Writes to x0 complete but never strobe the regfile
        step(); drive_alu(1, 0, 64'hFF);
        mid();  check("x0_alu_ready", bus.alu_ready, 1);
        step(); drive_alu(0, 0, 0); drive_ld(1, 0, 64'h77);
        mid();
        check("x0_alu_wr_en", bus.wr_en, 0);
        check("x0_alu_src",   bus.wr_src, 0);
        step(); drive_ld(0, 0, 0);
        mid();  check("x0_ld_count1", bus.ldq_count, 1);
        step(); mid();
        check("x0_ld_count0", bus.ldq_count, 0);
        check("x0_ld_wr_en",  bus.wr_en, 0);
        check("x0_ld_src",    bus.wr_src, 1);

        // Reset with two loads queued discards them
        step(); drive_alu(1, 2, 64'h22); drive_ld(1, 4, 64'h44);
        step(); drive_ld(1, 5, 64'h55);
        step(); drive_alu(0, 0, 0); drive_ld(0, 0, 0); rst = 1'b1;
        mid();
        check("mid_rst_count",     bus.ldq_count, 2);
        check("mid_rst_alu_ready", bus.alu_ready, 0);
        check("mid_rst_ld_ready",  bus.ld_ready,  0);
        step(); rst = 1'b0;
        mid();
        check("post_rst_count", bus.ldq_count, 0);
        check("post_rst_wr_en", bus.wr_en, 0);
        for (int i = 0; i < 4; i++) begin
            step(); mid();
            check("no_stale_wr_en", bus.wr_en, 0);
        end

        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
